// File: rtl/arbitro_mux_2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_mux_2_pkg
// Purpose  : Shared state encoding and source IDs for the two-way operand arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package arbitro_mux_2_pkg;

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        ESPERA = 1'b1
    } state_t;

    localparam logic SRC0 = 1'b0;
    localparam logic SRC1 = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mux_2_para_1.sv
`default_nettype none
// ============================================================================
// Module   : mux_2_para_1
// Purpose  : Single-bit 2:1 multiplexer; o_y follows i_d1 when i_s is high.
// Revision : 1.0 - initial release
// ============================================================================
module mux_2_para_1 (
    input  logic i_d0,
    input  logic i_d1,
    input  logic i_s,
    output logic o_y
);

    assign o_y = i_s ? i_d1 : i_d0;

endmodule
`default_nettype wire

// File: rtl/arbitro_mux_2.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_mux_2
// Purpose  : Round-robin arbiter steering one of two requesters into a
//            registered valid/ready output, with saturating service counters.
// Revision : 1.0 - initial release
// ============================================================================
module arbitro_mux_2
    import arbitro_mux_2_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_src,
    output logic             sel,
    output logic [CW-1:0]    cnt0,
    output logic [CW-1:0]    cnt1
);

    localparam logic [CW-1:0] C_CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] C_CNT_MAX = {CW{1'b1}};

    state_t           r_state;
    state_t           w_state_next;
    logic             r_prio;
    logic             r_out_src;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [CW-1:0]    r_cnt0;
    logic [CW-1:0]    r_cnt1;

    logic             w_has_winner;
    logic             w_winner;
    logic             w_sel;
    logic             w_accept;
    logic [WIDTH-1:0] w_mux_out;

    // Arbitration only happens while idle; prio breaks ties.
    always_comb begin
        w_has_winner = 1'b0;
        w_winner     = SRC0;
        if (r_state == OCIOSO) begin
            if (req0_valid && req1_valid) begin
                w_has_winner = 1'b1;
                w_winner     = r_prio;
            end else if (req0_valid) begin
                w_has_winner = 1'b1;
                w_winner     = SRC0;
            end else if (req1_valid) begin
                w_has_winner = 1'b1;
                w_winner     = SRC1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            OCIOSO:  if (w_has_winner) w_state_next = ESPERA;
            ESPERA:  if (out_ready)    w_state_next = OCIOSO;
            default: w_state_next = OCIOSO;
        endcase
    end

    assign w_sel    = (r_state == ESPERA) ? r_out_src : w_winner;
    assign w_accept = (r_state == ESPERA) && out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux_bank
            mux_2_para_1 u_mux (
                .i_d0 (req0_data[gi]),
                .i_d1 (req1_data[gi]),
                .i_s  (w_sel),
                .o_y  (w_mux_out[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= OCIOSO;
            r_prio      <= SRC0;
            r_out_src   <= SRC0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_has_winner) begin
                r_out_data  <= w_mux_out;
                r_out_src   <= w_winner;
                r_out_valid <= 1'b1;
            end
            if (w_accept) begin
                r_out_valid <= 1'b0;
                r_prio      <= ~r_out_src;
                // Counters saturate at all-ones rather than wrapping.
                if (r_out_src == SRC0) begin
                    if (r_cnt0 != C_CNT_MAX) r_cnt0 <= r_cnt0 + C_CNT_ONE;
                end else begin
                    if (r_cnt1 != C_CNT_MAX) r_cnt1 <= r_cnt1 + C_CNT_ONE;
                end
            end
        end
    end

    assign req0_ready = w_has_winner && (w_winner == SRC0);
    assign req1_ready = w_has_winner && (w_winner == SRC1);
    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_src    = r_out_src;
    assign sel        = w_sel;
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux_2.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_mux_2
// Purpose  : Scoreboard bench for arbitro_mux_2 with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_mux_2;

    localparam int WIDTH = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic             req0_ready, req1_ready;
    logic             out_valid, out_ready, out_src, sel;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    cnt0, cnt1;

    always #5 clk = ~clk;

    arbitro_mux_2 #(.WIDTH(WIDTH), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .out_src    (out_src),
        .sel        (sel),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             src;
    } item_t;

    item_t sbq[$];
    int    total = 0;
    int    bad   = 0;

    // Reference model: a "held" slot plus the identity of the last served source.
    bit               m_busy;
    bit               m_src;
    int               m_last;
    int               m_cnt [2];
    bit               m_after_rst;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit v0, input logic [WIDTH-1:0] d0,
                         input bit v1, input logic [WIDTH-1:0] d1, input bit ordy);
        bit has;
        int win;
        @(negedge clk);
        rst        = r;
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
        out_ready  = ordy;
        #1;
        if (r) begin
            sbq.delete();
            m_busy      = 0;
            m_src       = 0;
            m_last      = 1;
            m_cnt[0]    = 0;
            m_cnt[1]    = 0;
            m_after_rst = 1;
        end else begin
            has = !m_busy && (v0 || v1);
            if (v0 && v1)  win = 1 - m_last;
            else if (v1)   win = 1;
            else           win = 0;
            chk("out_valid", out_valid, m_busy);
            chk("cnt0", cnt0, m_cnt[0]);
            chk("cnt1", cnt1, m_cnt[1]);
            chk("req0_ready", req0_ready, has && win == 0);
            chk("req1_ready", req1_ready, has && win == 1);
            if (m_busy)   chk("sel_hold", sel, m_src);
            else if (has) chk("sel_grant", sel, win);
            if (m_after_rst) begin
                chk("out_data_rst", out_data, 0);
                chk("out_src_rst", out_src, 0);
                m_after_rst = 0;
            end
            if (m_busy) begin
                if (ordy) begin
                    if (m_cnt[m_src] < CMAX) m_cnt[m_src]++;
                    m_last = m_src;
                    m_busy = 0;
                end
            end else if (has) begin
                sbq.push_back('{data: (win == 1) ? d1 : d0, src: win[0]});
                m_src  = win[0];
                m_busy = 1;
            end
        end
    endtask

    // Monitor: pops one expected word on every output handshake.
    initial begin : monitor
        item_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_src", out_src, e.src);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req0_valid = 0; req1_valid = 0;
        req0_data = '0; req1_data = '0; out_ready = 0;

        // Reset with both requesters active; then req0 must win first.
        cycle(1, 1, 4'h3, 1, 4'hC, 1);
        cycle(1, 1, 4'h3, 1, 4'hC, 1);
        for (int i = 0; i < 4; i++) cycle(0, 1, 4'h3, 1, 4'hC, 1);

        // Single requester.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 4'hA, 1);

        // Contention and fairness.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle(0, 1, 4'h3, 1, 4'hC, 1);

        // Backpressure: hold req0's word while req1 waits.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 4'h5, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 4'h6, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 4'h6, 1);

        // Saturation of the narrow counter.
        cycle(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 11; i++) cycle(0, 1, i[3:0], 0, 0, 1);

        // Reset while a word is held; it must never appear.
        cycle(0, 1, 4'h9, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) < 2),
                  $urandom_range(0, 1) == 1, WIDTH'($urandom),
                  $urandom_range(0, 1) == 1, WIDTH'($urandom),
                  $urandom_range(0, 3) != 0);
        end

        // Drain and confirm every granted word was delivered.
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0, 1);
        chk("scoreboard_empty", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arbitro_mux_2.md
Name: arbitro_mux_2

Overview:
- Round-robin arbiter sharing one WIDTH-bit datapath between two requesters, each with a valid/ready handshake.
- The winner's data is steered through a per-bit bank of mux_2_para_1 instances into a registered output with a valid/ready handshake.
- Sits in front of the ULA operand path, so two sources (e.g. register-file port and immediate/feedback path) can feed a single operand input.
- Keeps per-requester saturating service counters for debug.

Parameters:
- WIDTH, 4: data width of each requester and of the output.
- CW, 8: width of each service counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has data.
- req0_data  input  WIDTH  requester 0 data.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req1_valid  input  1  requester 1 has data.
- req1_data  input  WIDTH  requester 1 data.
- req1_ready  output  1  requester 1 transfer accepted this cycle.
- out_valid  output  1  out_data holds a granted word.
- out_data  output  WIDTH  registered selected word.
- out_ready  input  1  consumer accepts the word.
- out_src  output  1  source of the held word (0 = req0, 1 = req1); registered.
- sel  output  1  current mux select (combinational); exported for observation.
- cnt0  output  CW  words delivered from req0 (saturating).
- cnt1  output  CW  words delivered from req1 (saturating).

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values (on the rst edge, regardless of state or mid-transfer):
  - state = OCIOSO, out_valid = 0, out_data = 0, out_src = 0.
  - Priority pointer prio = 0 (req0 favoured first).
  - cnt0 = 0, cnt1 = 0.
  - A word held in ESPERA is discarded.
- States: OCIOSO (no word held), ESPERA (word held, waiting for out_ready).
- Winner (combinational, evaluated in OCIOSO only):
  - Only one valid: that requester wins.
  - Both valid: the requester equal to prio wins.
  - Neither valid: no winner.
- sel = winner index in OCIOSO; sel = out_src in ESPERA.
- reqN_ready = 1 only in OCIOSO and only for the winner; it may depend combinationally on reqN_valid. Both readys are 0 in ESPERA.
- Transfer in OCIOSO (winner exists):
  - out_data <= mux output (WIDTH mux_2_para_1 instances, D0 = req0_data, D1 = req1_data, S = sel).
  - out_src <= winner, out_valid <= 1, state -> ESPERA.
  - Latency: 1 cycle from the input handshake to out_valid.
- ESPERA:
  - out_data and out_src stay stable while out_ready = 0, with no limit on how long.
  - On out_ready = 1:
    - out_valid <= 0, state -> OCIOSO.
    - prio <= ~out_src.
    - cnt[out_src] increments unless already at 2^CW-1; it saturates there and never wraps.
- Throughput: at most 1 word per 2 cycles. ESPERA and OCIOSO never overlap, so an accept and a new grant are never in the same cycle.
- out_ready while out_valid = 0 is ignored.
- A requester dropping valid before ready is legal; arbitration is re-evaluated every OCIOSO cycle with no grant memory.
- Fairness: with both valid continuously, grants alternate 0,1,0,1,... A requester never waits more than one service of the other.
- Counters change only on output acceptance, not on input transfer.

Decomposition:
- Shared package holds:
  - State encoding OCIOSO = 1'b0, ESPERA = 1'b1.
  - Source IDs SRC0 = 0, SRC1 = 1.
- Natural sub-module: the existing mux_2_para_1, instantiated WIDTH times in a generate loop to form the data steering bank.
- No other sub-modules; the FSM, pointer and counters live in arbitro_mux_2.

Test Plan:
- Reset behaviour: rst high for 2 cycles with both valid = 1 -> out_valid = 0, readys = 0, cnt0 = cnt1 = 0, out_data = 0. After release, the first grant goes to req0.
- Single requester: req1_valid = 1, req1_data = 4'hA, out_ready = 1 -> req1_ready = 1 in cycle 0; out_valid = 1, out_data = 4'hA, out_src = 1 in cycle 1; cnt1 = 1 in cycle 2.
- Contention and fairness: both valid continuously with data 4'h3 / 4'hC, out_ready = 1 -> output sequence 3,C,3,C, one word every 2 cycles; cnt0 = cnt1 = 2 after 8 cycles.
- Backpressure: grant req0 = 4'h5, hold out_ready = 0 for 5 cycles while req1 is valid -> out_data stays 4'h5, req1_ready = 0 throughout. After out_ready = 1, req1 is granted next.
- Saturation: CW = 2, deliver 5 words from req0 -> cnt0 reads 3 after the 3rd, 4th and 5th words.
- Reset mid-operation: rst asserted while in ESPERA holding 4'h9 -> next cycle out_valid = 0, prio = 0, counters = 0, and the held word is never delivered.
